timer_mm_ss: RTL and testbench

Down-counting M:SS timer that consumes the decade-counter function of the minutos_segundos datapath. It holds three BCD digits: minutes ones (0-9), seconds tens (0-5) and seconds ones (0-9). Digits are entered serially from a keypad digit bus. The timer then counts down once per external 1 Hz enable. A control FSM handles start, pause, resume and cancel, and signals completion to the downstream display/alarm logic.

---
 rtl/timer_mm_ss.sv | 130 +++++++++++++
 tb/tb_timer_mm_ss.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_mm_ss.sv
// Down-counting M:SS timer: serial BCD keypad entry in IDLE, countdown on a 1 Hz enable,
// and pause/resume/cancel control with a fixed-length completion pulse.
module timer_mm_ss #(
  parameter int DONE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] data,
  input  logic       load,
  input  logic       en,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       tc
);

  localparam int CW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] done_cnt;
  logic          entry_ok;
  logic          at_one;
  logic          running_d;
  logic          paused_d;
  logic          done_d;

  assign tc       = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign entry_ok = load && (data <= 4'd9);
  assign at_one   = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= S_IDLE;
      running  <= 1'b0;
      paused   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      running  <= running_d;
      paused   <= paused_d;
      done     <= done_d;
    end
  end

  // In IDLE a valid digit load or a clear both take priority over start.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (!entry_ok && !stop && start && !tc) next_state = S_RUN;
      S_RUN: begin
        if (stop)              next_state = S_PAUSE;
        else if (en && at_one) next_state = S_DONE;
      end
      S_PAUSE: begin
        if (stop)       next_state = S_IDLE;
        else if (start) next_state = S_RUN;
      end
      S_DONE:  if (done_cnt == CW'(DONE_CYCLES - 1)) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    running_d = (next_state == S_RUN);
    paused_d  = (next_state == S_PAUSE);
    done_d    = (next_state == S_DONE);
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn)              done_cnt <= '0;
    else if (state != S_DONE) done_cnt <= '0;
    else                      done_cnt <= done_cnt + 1'b1;
  end

  // Digit datapath: shift-in entry, clear, and decrement with borrow across the seconds digits.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (entry_ok) begin
            min_ones <= sec_tens;
            sec_tens <= (sec_ones > 4'd5) ? 4'd5 : sec_ones;
            sec_ones <= data;
          end else if (stop) begin
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
        end
        S_RUN: begin
          if (!stop && en) begin
            if (sec_ones != 4'd0) begin
              sec_ones <= sec_ones - 4'd1;
            end else begin
              sec_ones <= 4'd9;
              if (sec_tens != 4'd0) begin
                sec_tens <= sec_tens - 4'd1;
              end else begin
                sec_tens <= 4'd5;
                min_ones <= min_ones - 4'd1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_mm_ss.sv
// Directed and randomized checks of timer_mm_ss against a seconds-count reference model.
module tb_timer_mm_ss;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       clearn;
  logic [3:0] data;
  logic       load;
  logic       en;
  logic       start;
  logic       stop;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       paused;
  logic       done;
  logic       tc;

  int compared   = 0;
  int mismatched = 0;

  // Model: total seconds plus mode (0 idle, 1 run, 2 pause, 3 done) and done cycles left.
  int m_secs = 0;
  int m_mode = 0;
  int m_left = 0;

  timer_mm_ss #(.DONE_CYCLES(DC)) dut (
    .clk(clk), .clearn(clearn), .data(data), .load(load), .en(en),
    .start(start), .stop(stop), .min_ones(min_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .running(running), .paused(paused), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_secs = 0;
    m_mode = 0;
    m_left = 0;
  endfunction

  function automatic void model_edge(input logic ld, input logic [3:0] d,
                                     input logic st, input logic sp, input logic e);
    int tens;
    int ones;
    case (m_mode)
      0: begin
        tens = (m_secs % 60) / 10;
        ones = m_secs % 10;
        if (ld && d <= 9)
          m_secs = tens * 60 + ((ones > 5) ? 5 : ones) * 10 + int'(d);
        else if (sp)
          m_secs = 0;
        else if (st && m_secs != 0)
          m_mode = 1;
      end
      1: begin
        if (sp) m_mode = 2;
        else if (e) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_mode = 3;
            m_left = DC;
          end
        end
      end
      2: begin
        if (sp) begin
          m_secs = 0;
          m_mode = 0;
        end else if (st) m_mode = 1;
      end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endfunction

  task automatic check_output(input string tag);
    logic [15:0] obs;
    logic [15:0] exp;
    exp = {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
           (m_mode == 1), (m_mode == 2), (m_mode == 3), (m_secs == 0)};
    obs = {min_ones, sec_tens, sec_ones, running, paused, done, tc};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ld, input logic [3:0] d, input logic st,
                                input logic sp, input logic e, input string tag);
    @(negedge clk);
    load  = ld;
    data  = d;
    start = st;
    stop  = sp;
    en    = e;
    @(posedge clk);
    model_edge(ld, d, st, sp, e);
    #1;
    check_output(tag);
  endtask

  task automatic enter_digit(input logic [3:0] d, input string tag);
    apply_stimulus(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic tick(input string tag);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic idle_cycle(input string tag);
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic       r_ld;
    logic       r_st;
    logic       r_sp;
    logic       r_en;
    logic [3:0] r_d;
    int         r;

    clearn = 1'b1;
    data = 4'd0; load = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0;
    #3 clearn = 1'b0;
    model_reset();
    #10 check_output("reset_state");
    @(negedge clk) clearn = 1'b1;

    // Asynchronous reset in the middle of a countdown at 3:27
    enter_digit(4'd3, "entry_0_03");
    enter_digit(4'd2, "entry_0_32");
    enter_digit(4'd7, "entry_3_27");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "start_3_27");
    @(negedge clk);
    #2 clearn = 1'b0;
    model_reset();
    #1 check_output("async_reset_midrun");
    @(negedge clk) clearn = 1'b1;
    idle_cycle("after_reset");

    enter_digit(4'd1, "entry_a1");
    enter_digit(4'd3, "entry_a2");
    enter_digit(4'd0, "entry_1_30");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "idle_stop_clear");
    enter_digit(4'd1, "entry_b1");
    enter_digit(4'd7, "entry_b2");
    enter_digit(4'd2, "entry_sat_1_52");
    enter_digit(4'hC, "entry_invalid");
    apply_stimulus(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, "load_beats_start");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "idle_stop_clear2");

    // Full countdown from 1:00 including the done pulse
    enter_digit(4'd1, "entry_c1");
    enter_digit(4'd0, "entry_c2");
    enter_digit(4'd0, "entry_1_00");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "start_no_dec");
    tick("borrow_0_59");
    for (int i = 0; i < 59; i++) tick("countdown");
    for (int i = 0; i < DC + 1; i++) idle_cycle("done_pulse");

    // Pause with a coincident tick, ignored ticks, resume, cancel
    enter_digit(4'd4, "entry_d1");
    enter_digit(4'd5, "entry_0_45");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "start_0_45");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, "stop_beats_en");
    for (int i = 0; i < 3; i++) tick("pause_ignores_en");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "resume");
    tick("resume_0_44");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "pause_again");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, "pause_stop_wins");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "zero_start_stays_idle");

    // Entry saturation caps minutes at 5, so 5:59 is the largest enterable value
    enter_digit(4'd9, "entry_e1");
    enter_digit(4'd9, "entry_e2");
    enter_digit(4'd9, "entry_5_59");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "start_5_59");
    tick("dec_5_58");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "pause_5_58");
    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "cancel_5_58");
    enter_digit(4'd1, "entry_0_01");
    apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, "start_0_01");
    tick("done_same_edge");
    for (int i = 0; i < DC; i++) apply_stimulus(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, "done_ignores_inputs");

    for (int i = 0; i < 600; i++) begin
      r    = int'($urandom_range(0, 9));
      r_ld = (r < 3);
      r_st = (r == 3) || (r == 4);
      r_sp = (r == 5);
      if (r == 6 && m_mode == 2) begin
        r_st = 1'b1;
        r_sp = 1'b1;
      end
      r_en = 1'($urandom_range(0, 1));
      r_d  = 4'($urandom_range(0, 15));
      apply_stimulus(r_ld, r_d, r_st, r_sp, r_en, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
